// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the encoder and the channel decoder.
//   - TMDS_CTRL_xx : the four 10-bit control tokens (bit 0 first on the wire)
//   - tmds_dec_state_e : word-alignment FSM states of the decoder
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } tmds_dec_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classify-and-decode of one 10-bit TMDS symbol.
// Ports:
//   symbol_i  [9:0]  TMDS symbol, bit 0 first on the wire
//   d_o       [7:0]  decoded byte (meaningful only when is_ctrl_o=0)
//   is_ctrl_o        symbol is one of the four control tokens
//   c_o       [1:0]  {C1,C0} of the control token (0 for data)
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] symbol_i,
  output logic [7:0] d_o,
  output logic       is_ctrl_o,
  output logic [1:0] c_o
);

  logic [7:0] q;

  always_comb begin
    is_ctrl_o = 1'b1;
    c_o       = 2'b00;
    unique case (symbol_i)
      TMDS_CTRL_00: c_o = 2'b00;
      TMDS_CTRL_01: c_o = 2'b01;
      TMDS_CTRL_10: c_o = 2'b10;
      TMDS_CTRL_11: c_o = 2'b11;
      default:      is_ctrl_o = 1'b0;
    endcase
  end

  // Undo DC-balance inversion, then undo XOR (bit 8 = 1) or XNOR chaining.
  always_comb begin
    q      = symbol_i[9] ? ~symbol_i[7:0] : symbol_i[7:0];
    d_o    = 8'h00;
    d_o[0] = q[0];
    for (int i = 1; i < 8; i++)
      d_o[i] = symbol_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: registered symbol decode plus a word-alignment
// FSM that asks the deserialiser for bitslips until control-token runs appear.
// Optional error counter enabled by defining TMDS_DEC_ERR_CNT_EN.
// Ports:
//   pixclk            pixel clock
//   rst_n             asynchronous active-low reset
//   symbol_in  [9:0]  deserialised TMDS symbol
//   data_out   [7:0]  decoded byte, valid when de_out=1, holds during control
//   de_out            1 = data symbol, 0 = control token
//   ctrl_out   [1:0]  {C1,C0} of the last control token
//   locked            word alignment established
//   bitslip           one-cycle request to shift alignment by one bit
//   err_count [15:0]  (TMDS_DEC_ERR_CNT_EN only) lock losses + bitslips, saturating
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_RUN      = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_HOLD     = 16,
  parameter int LOSS_WINDOW   = 2048
) (
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic [9:0]  symbol_in,
  output logic [7:0]  data_out,
  output logic        de_out,
  output logic [1:0]  ctrl_out,
  output logic        locked,
  output logic        bitslip
`ifdef TMDS_DEC_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int MAX_A   = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
  localparam int MAX_WIN = (MAX_A > SLIP_HOLD) ? MAX_A : SLIP_HOLD;
  localparam int CW      = $clog2(MAX_WIN) + 1;
  localparam int RW      = $clog2(LOCK_RUN) + 1;

  localparam logic [CW-1:0] SRCH_LAST = CW'(SEARCH_WINDOW - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SLIP_HOLD - 1);
  localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_WINDOW - 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(LOCK_RUN);

  logic [7:0] dec_d;
  logic       dec_ctrl;
  logic [1:0] dec_c;

  tmds_symbol_decode u_dec (
    .symbol_i  (symbol_in),
    .d_o       (dec_d),
    .is_ctrl_o (dec_ctrl),
    .c_o       (dec_c)
  );

  tmds_dec_state_e state_q, state_d;
  logic [CW-1:0]   tmr_q, tmr_d;
  logic [RW-1:0]   run_q, run_d, run_inc;
  logic            slip_d, slip_q, drop;
  logic            locked_q;
  logic [7:0]      data_q;
  logic            de_q;
  logic [1:0]      ctrl_q;

  assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    run_d   = dec_ctrl ? run_inc : '0;
    slip_d  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      SEARCH: begin
        tmr_d = tmr_q + 1'b1;
        // run_d already includes this cycle's symbol, so lock lands on the
        // same edge that outputs the LOCK_RUN-th token; lock beats slip.
        if (run_d == RUN_MAX) begin
          state_d = LOCKED;
          tmr_d   = '0;
        end else if (tmr_q == SRCH_LAST) begin
          state_d = SLIP_WAIT;
          tmr_d   = '0;
          run_d   = '0;
          slip_d  = 1'b1;
        end
      end
      SLIP_WAIT: begin
        run_d = '0;
        if (tmr_q == HOLD_LAST) begin
          state_d = SEARCH;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      LOCKED: begin
        if (dec_ctrl) begin
          tmr_d = '0;
        end else if (tmr_q == LOSS_LAST) begin
          state_d = SEARCH;
          tmr_d   = '0;
          run_d   = '0;
          drop    = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
        tmr_d   = '0;
        run_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      tmr_q    <= '0;
      run_q    <= '0;
      slip_q   <= 1'b0;
      locked_q <= 1'b0;
      data_q   <= 8'h00;
      de_q     <= 1'b0;
      ctrl_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      run_q    <= run_d;
      slip_q   <= slip_d;
      locked_q <= (state_d == LOCKED);
      de_q     <= ~dec_ctrl;
      if (dec_ctrl) ctrl_q <= dec_c;
      else          data_q <= dec_d;
    end
  end

`ifdef TMDS_DEC_ERR_CNT_EN
  logic [15:0] err_q;
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n)                             err_q <= 16'h0000;
    else if ((slip_d || drop) && err_q != 16'hFFFF) err_q <= err_q + 16'h0001;
  end
  assign err_count = err_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign data_out = data_q;
  assign de_out   = de_q;
  assign ctrl_out = ctrl_q;
  assign locked   = locked_q;
  assign bitslip  = slip_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: the driver pushes the expected
// registered outputs for every symbol it applies; the monitor pops one entry
// per clock edge and compares.
module tb_tmds_channel_decoder;
  import tmds_pkg::*;

  logic        pixclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [9:0]  symbol_in = 10'h000;
  logic [7:0]  data_out;
  logic        de_out;
  logic [1:0]  ctrl_out;
  logic        locked;
  logic        bitslip;
`ifdef TMDS_DEC_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  tmds_channel_decoder dut (
    .pixclk    (pixclk),
    .rst_n     (rst_n),
    .symbol_in (symbol_in),
    .data_out  (data_out),
    .de_out    (de_out),
    .ctrl_out  (ctrl_out),
    .locked    (locked),
    .bitslip   (bitslip)
`ifdef TMDS_DEC_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 pixclk = ~pixclk;

  typedef struct {
    logic [7:0] data;
    logic       de;
    logic [1:0] ctrl;
    logic       lock;
    logic       slip;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endfunction

  // Monitor: outputs are registered, so compare 1 time unit after each edge.
  initial forever begin
    @(posedge pixclk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".data"}, {8'h00, data_out}, {8'h00, e.data});
      chk({e.tag, ".de"},   {15'h0, de_out},   {15'h0, e.de});
      chk({e.tag, ".ctrl"}, {14'h0, ctrl_out}, {14'h0, e.ctrl});
      chk({e.tag, ".lock"}, {15'h0, locked},   {15'h0, e.lock});
      chk({e.tag, ".slip"}, {15'h0, bitslip},  {15'h0, e.slip});
    end
  end

  task automatic send(input logic [9:0] s, input logic [7:0] d, input logic de,
                      input logic [1:0] c, input logic lk, input logic sl, input string tag);
    exp_t x;
    @(negedge pixclk);
    symbol_in = s;
    x.data = d; x.de = de; x.ctrl = c; x.lock = lk; x.slip = sl; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge pixclk);
      #2;
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 16'(q.size()), 16'h0);
      q.delete();
    end
  endtask

  // Asserted between edges; outputs must clear without a clock edge.
  // Released mid-high phase so the next edge is cycle 0 of the new run.
  task automatic do_reset(input string tag);
    @(posedge pixclk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, ".data"}, {8'h00, data_out}, 16'h0);
    chk({tag, ".de"},   {15'h0, de_out},   16'h0);
    chk({tag, ".ctrl"}, {14'h0, ctrl_out}, 16'h0);
    chk({tag, ".lock"}, {15'h0, locked},   16'h0);
    chk({tag, ".slip"}, {15'h0, bitslip},  16'h0);
`ifdef TMDS_DEC_ERR_CNT_EN
    chk({tag, ".err"},  err_count,         16'h0);
`endif
    @(posedge pixclk);
    #2;
    rst_n = 1'b1;
  endtask

  // Reference TMDS encoder (transition minimisation + caller-chosen inversion).
  function automatic logic [9:0] enc(input logic [7:0] b, input logic inv);
    int         n;
    logic       xn;
    logic [8:0] qm;
    n     = $countones(b);
    xn    = (n > 4) || (n == 4 && !b[0]);
    qm    = 9'h000;
    qm[0] = b[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    qm[8] = ~xn;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  initial begin
    // Reset state
    do_reset("rst0");

    // Constant data symbol from reset: 10'h1F0 decodes to 8'h10 (XOR, no invert).
    // Slips at cycle 2047 and 2047+16+2048 = 4111.
    for (int k = 0; k <= 4112; k++)
      send(10'h1F0, 8'h10, 1'b1, 2'b00, 1'b0, (k == 2047 || k == 4111), "slip");
    drain();
`ifdef TMDS_DEC_ERR_CNT_EN
    chk("err_after_2_slips", err_count, 16'd2);
`endif

    // 7 tokens then data: no lock
    do_reset("rst1");
    for (int k = 0; k < 7; k++)
      send(TMDS_CTRL_00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, "run7");
    send(10'h1F0, 8'h10, 1'b1, 2'b00, 1'b0, 1'b0, "run7_data");

    // 8 consecutive tokens of all four kinds: lock on the 8th
    send(TMDS_CTRL_01, 8'h10, 1'b0, 2'b01, 1'b0, 1'b0, "acq_c01a");
    send(TMDS_CTRL_01, 8'h10, 1'b0, 2'b01, 1'b0, 1'b0, "acq_c01b");
    send(TMDS_CTRL_10, 8'h10, 1'b0, 2'b10, 1'b0, 1'b0, "acq_c10a");
    send(TMDS_CTRL_10, 8'h10, 1'b0, 2'b10, 1'b0, 1'b0, "acq_c10b");
    send(TMDS_CTRL_11, 8'h10, 1'b0, 2'b11, 1'b0, 1'b0, "acq_c11a");
    send(TMDS_CTRL_11, 8'h10, 1'b0, 2'b11, 1'b0, 1'b0, "acq_c11b");
    send(TMDS_CTRL_00, 8'h10, 1'b0, 2'b00, 1'b0, 1'b0, "acq_c00a");
    send(TMDS_CTRL_00, 8'h10, 1'b0, 2'b00, 1'b1, 1'b0, "acq_lock");

    // Directed data decode. 10'b1011111111: q=00, XNOR chain gives 8'hFE.
    send(10'b0100000000, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, "dec_100");
    send(10'b1011111111, 8'hFE, 1'b1, 2'b00, 1'b1, 1'b0, "dec_3ff");

    // Round-trip sweep, mixing inverted and non-inverted encodings
    for (int b = 0; b < 256; b++)
      send(enc(8'(b), b[0] ^ b[3]), 8'(b), 1'b1, 2'b00, 1'b1, 1'b0, "sweep");
    send(TMDS_CTRL_10, 8'hFF, 1'b0, 2'b10, 1'b1, 1'b0, "hold_data");

    // Token at timer 2046 keeps lock
    for (int j = 1; j <= 2046; j++)
      send(enc(8'h5A, 1'b0), 8'h5A, 1'b1, 2'b10, 1'b1, 1'b0, "loss_pre");
    send(TMDS_CTRL_11, 8'h5A, 1'b0, 2'b11, 1'b1, 1'b0, "loss_rescue");

    // 2048 data symbols: lock falls on the 2048th, no bitslip
    for (int j = 1; j <= 2051; j++)
      send(enc(8'h5A, 1'b1), 8'h5A, 1'b1, 2'b11, (j < 2048), 1'b0, "loss");

    // Relock, stream data, then async reset mid-line
    for (int k = 1; k <= 8; k++)
      send(TMDS_CTRL_00, 8'h5A, 1'b0, 2'b00, (k == 8), 1'b0, "relock");
    for (int k = 0; k < 5; k++)
      send(enc(8'h33, k[0]), 8'h33, 1'b1, 2'b00, 1'b1, 1'b0, "pre_rst");
    drain();
`ifdef TMDS_DEC_ERR_CNT_EN
    chk("err_after_loss", err_count, 16'd1);
`endif
    do_reset("rst_async");
    for (int k = 0; k <= 2048; k++)
      send(10'h1F0, 8'h10, 1'b1, 2'b00, 1'b0, (k == 2047), "post_rst");
    drain();
`ifdef TMDS_DEC_ERR_CNT_EN
    chk("err_post_rst", err_count, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
